// File: rtl/debug_scan_controller.sv
// Debug scan controller: walks the debug mux through every membrane-potential word plus the
// spike word, streams each captured word out over a valid/ready handshake, then restores the
// user's debug selection. Optionally repeats after an idle gap.
module debug_scan_controller #(
  parameter int unsigned NUM_POT  = 10,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          user_cfg,
  output logic                cfg_en,
  output logic [7:0]          cfg_data,
  input  logic [7:0]          dbg_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic [3:0]          out_idx,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StSample,
    StSend,
    StRestore,
    StGap
  } state_e;

  localparam logic [3:0]          LastIdx = 4'(NUM_POT);
  localparam logic [PERIOD_W-1:0] One     = {{(PERIOD_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [PERIOD_W-1:0] gap_q, gap_d;
  logic                aborted_q, aborted_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [3:0]          out_idx_q, out_idx_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic                xfer;

  assign xfer = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      gap_q       <= '0;
      aborted_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      aborted_q   <= aborted_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    aborted_d   = aborted_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        aborted_d = 1'b0;
        if (start && !abort) begin
          state_d = StCfg;
          idx_d   = '0;
        end
      end
      StCfg: begin
        if (abort) begin
          state_d   = StRestore;
          aborted_d = 1'b1;
        end else begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (abort) begin
          state_d   = StRestore;
          aborted_d = 1'b1;
        end else begin
          state_d     = StSend;
          out_valid_d = 1'b1;
          out_data_d  = dbg_data;
          out_idx_d   = idx_q;
          out_last_d  = (idx_q == LastIdx);
        end
      end
      StSend: begin
        // An abort here is remembered until the pending word has been accepted.
        if (abort) aborted_d = 1'b1;
        if (xfer) begin
          out_valid_d = 1'b0;
          if (out_last_q || aborted_d) begin
            state_d = StRestore;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StCfg;
          end
        end
      end
      StRestore: begin
        done_d = 1'b1;
        if (aborted_q || abort || (period == '0)) begin
          state_d = StIdle;
        end else begin
          state_d = StGap;
          gap_d   = period - One;
        end
      end
      StGap: begin
        if (abort) begin
          state_d   = StRestore;
          aborted_d = 1'b1;
        end else if (gap_q == '0) begin
          state_d = StCfg;
          idx_d   = '0;
        end else begin
          gap_d = gap_q - One;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cfg_en   = 1'b0;
    cfg_data = '0;
    unique case (state_q)
      StCfg: begin
        cfg_en   = 1'b1;
        cfg_data = (idx_q == LastIdx) ? 8'hFF : 8'(idx_q);
      end
      StRestore: begin
        cfg_en   = 1'b1;
        cfg_data = user_cfg;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule
